counter_checker: RTL and testbench



---
 rtl/counter_checker_pkg.sv | 16 +
 rtl/counter_checker_sat_counter.sv | 34 +++
 rtl/counter_checker.sv | 110 +++++++++++
 tb/tb_counter_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_checker_pkg.sv
// Shared types and default constants for the counter stream checker.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int unsigned LOCK_COUNT_DEF  = 4;
    localparam int unsigned UNLOCK_ERRS_DEF = 3;
    localparam int unsigned ERR_CNT_W_DEF   = 16;
    // Run and miss streaks never exceed 255, so eight bits cover every legal setting.
    localparam int unsigned STREAK_W        = 8;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating up-counter: clear beats increment, and the count holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_checker.sv
// Receive-side checker proving a count stream increments by one per valid sample,
// with lock acquisition, per-error flagging and a saturating error tally.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF,
    parameter int unsigned UNLOCK_ERRS = UNLOCK_ERRS_DEF,
    parameter int unsigned ERR_CNT_W   = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 valid_in,
    input  logic                 clear_stats,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    state_e                state_q;
    logic [WIDTH-1:0]      expected_q;
    logic [STREAK_W-1:0]   run_q;
    logic [STREAK_W-1:0]   miss_q;
    logic                  locked_q;
    logic                  err_pulse_q;

    logic [WIDTH-1:0]      expected_d;
    logic [STREAK_W-1:0]   run_inc;
    logic [STREAK_W-1:0]   miss_inc;
    logic                  match;
    logic                  locked_miss;

    assign expected_d  = count_in + WIDTH'(1);
    assign run_inc     = run_q + STREAK_W'(1);
    assign miss_inc    = miss_q + STREAK_W'(1);
    assign match       = (count_in == expected_q);
    assign locked_miss = valid_in && (state_q == LOCKED) && !match;

    // Sequence tracker; every valid sample realigns expected to the value just seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (valid_in) begin
                expected_q <= expected_d;
                case (state_q)
                    HUNT: begin
                        run_q   <= STREAK_W'(1);
                        state_q <= VERIFY;
                    end
                    VERIFY: begin
                        if (match) begin
                            run_q <= run_inc;
                            if (run_inc == STREAK_W'(LOCK_COUNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            run_q <= STREAK_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_q <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (miss_inc == STREAK_W'(UNLOCK_ERRS)) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                run_q    <= '0;
                                miss_q   <= '0;
                            end else begin
                                miss_q <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                        miss_q   <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (locked_miss),
        .clr_i   (clear_stats),
        .count_o (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed scenarios plus random traffic
// compared against a behavioural sequence model.
module tb_counter_checker;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned LOCK   = 4;
    localparam int unsigned UNLOCK = 3;
    localparam int unsigned ECW    = 4;
    localparam int          MODV   = 1 << WIDTH;
    localparam int          ERRMAX = (1 << ECW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] count_in;
    logic             valid_in;
    logic             clear_stats;
    logic             locked;
    logic             err_pulse;
    logic [ECW-1:0]   err_count;
    logic [WIDTH-1:0] expected;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: lock status, streak lengths and the value the next sample must carry.
    bit m_hunting;
    bit m_locked;
    bit m_pulse;
    int m_run;
    int m_miss;
    int m_exp;
    int m_err;

    counter_checker #(
        .WIDTH       (WIDTH),
        .LOCK_COUNT  (LOCK),
        .UNLOCK_ERRS (UNLOCK),
        .ERR_CNT_W   (ECW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .valid_in    (valid_in),
        .clear_stats (clear_stats),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .expected    (expected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void m_reset();
        m_hunting = 1'b1;
        m_locked  = 1'b0;
        m_pulse   = 1'b0;
        m_run     = 0;
        m_miss    = 0;
        m_exp     = 0;
        m_err     = 0;
    endfunction

    function automatic void m_step(input bit v, input int c, input bit clr);
        m_pulse = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (m_hunting) begin
                    m_hunting = 1'b0;
                    m_run     = 1;
                end else if (c == m_exp) begin
                    m_run++;
                    if (m_run >= LOCK) m_locked = 1'b1;
                end else begin
                    m_run = 1;
                end
            end else if (c == m_exp) begin
                m_miss = 0;
            end else begin
                m_pulse = 1'b1;
                if (m_err < ERRMAX) m_err++;
                m_miss++;
                if (m_miss == UNLOCK) begin
                    m_locked  = 1'b0;
                    m_hunting = 1'b1;
                    m_miss    = 0;
                    m_run     = 0;
                end
            end
            m_exp = (c + 1) % MODV;
        end
        if (clr) m_err = 0;
    endfunction

    function automatic int bad_value();
        return (m_exp + 1 + int'($urandom_range(0, MODV - 2))) % MODV;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".locked"},    int'(locked),    int'(m_locked));
        check({tag, ".err_pulse"}, int'(err_pulse), int'(m_pulse));
        check({tag, ".err_count"}, int'(err_count), m_err);
        check({tag, ".expected"},  int'(expected),  m_exp);
    endtask

    task automatic drive(input bit v, input int c, input bit clr, input string tag);
        @(negedge clk);
        valid_in    = v;
        count_in    = WIDTH'(c);
        clear_stats = clr;
        @(posedge clk);
        m_step(v, c, clr);
        #1;
        check_all(tag);
    endtask

    task automatic burst(input int start, input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1'b1, (start + i) % MODV, 1'b0, tag);
    endtask

    initial begin
        rst         = 1'b1;
        valid_in    = 1'b0;
        count_in    = '0;
        clear_stats = 1'b0;
        m_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean stream from reset: lock appears after the fourth sample.
        burst(0, 3, "ramp");
        check("pre_lock", int'(locked), 0);
        burst(3, 1, "ramp");
        check("lock_after_3", int'(locked), 1);

        // Run through the 15 -> 0 wrap while locked.
        burst(4, 14, "wrap");
        check("wrap_locked", int'(locked), 1);
        check("wrap_no_err", int'(err_count), 0);

        // Single injected error realigns expected and keeps lock.
        drive(1'b1, 9, 1'b0, "inject");
        check("inject_pulse", int'(err_pulse), 1);
        check("inject_exp", int'(expected), 10);
        check("inject_cnt", int'(err_count), 1);
        burst(10, 2, "after_inject");
        check("inject_held", int'(locked), 1);

        // Three consecutive bad samples drop lock; a fresh run relocks.
        drive(1'b1, 3, 1'b0, "bad3");
        drive(1'b1, 8, 1'b0, "bad3");
        drive(1'b1, 1, 1'b0, "bad3");
        check("unlock", int'(locked), 0);
        check("unlock_cnt", int'(err_count), 4);
        burst(2, 4, "relock");
        check("relock", int'(locked), 1);

        // Gaps in valid_in change nothing.
        burst(6, 2, "gap");
        drive(1'b0, 13, 1'b0, "gap");
        drive(1'b0, 2, 1'b0, "gap");
        burst(8, 2, "gap");

        // Alternate bad/good samples to drive err_count into saturation.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, bad_value(), 1'b0, "sat");
            drive(1'b1, m_exp, 1'b0, "sat");
        end
        check("saturated", int'(err_count), ERRMAX);
        check("sat_locked", int'(locked), 1);

        // Clear coincident with a counted mismatch: clear wins, pulse still fires.
        drive(1'b1, bad_value(), 1'b1, "clr_hit");
        check("clr_hit_cnt", int'(err_count), 0);
        check("clr_hit_pulse", int'(err_pulse), 1);
        drive(1'b1, m_exp, 1'b0, "clr_hit");
        drive(1'b1, bad_value(), 1'b0, "two_err");
        drive(1'b1, m_exp, 1'b0, "two_err");
        drive(1'b1, bad_value(), 1'b0, "two_err");
        check("two_err_cnt", int'(err_count), 2);

        // Asynchronous reset mid-lock, observed before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, mostly in-sequence with occasional errors and clears.
        for (int i = 0; i < 1500; i++) begin
            bit v;
            bit clr;
            int c;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            c   = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, MODV - 1));
            drive(v, c, clr, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
